multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle RV32I control unit, directly upstream of the ALU.
- Sequences each instruction through a Moore FSM and drives the datapath mux selects, write enables and the 3-bit ALUControl.
- Consumes the ALU status flags zero, lt and bge to resolve conditional branches.
- Datapath registers (PC, OldPC, IR, Data, A, B, ALUOut) live outside this block.

Parameters:
- ALUCTL_W, 3, width of ALUControl.
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU: ALUResult==0.
- lt  in  1  ALU: signed SrcA<SrcB.
- bge  in  1  ALU: signed SrcA>=SrcB.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  IR and OldPC load enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 0=ALUOut, 1=Data, 2=ALUResult, 3=ImmExt.
- ALUSrcA  out  2  ALU A select: 0=PC, 1=OldPC, 2=A.
- ALUSrcB  out  2  ALU B select: 0=B, 1=ImmExt, 2=const 4.
- ImmSrc  out  3  immediate format: 0=I, 1=S, 2=B, 3=J, 4=U.
- ALUControl  out  3  ALU operation code.

Behaviour:
- Reset: rst_n low asynchronously forces state=FETCH; FETCH outputs appear immediately. Reset mid-instruction abandons it; no write enables are asserted after reset. Exit from reset is on the first rising edge with rst_n high.
- All outputs decode from state, plus op/funct3/funct7b5/flags (Moore, except the branch PCWrite). The state register is the only flop.
- ALUControl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU; 7 is unused and never driven.
- Default outputs in every state: enables 0, selects 0, ALUControl=ADD.
- States and per-state outputs:
  - FETCH(0): AdrSrc=0, IRWrite=1, ALUSrcA=0, ALUSrcB=2, ResultSrc=2, PCWrite=1. Next: DECODE.
  - DECODE(1): ALUSrcA=1, ALUSrcB=1 (computes branch/JAL target into ALUOut). Next state by op:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - any other -> FETCH (treated as NOP, no writes)
  - MEMADR(2): ALUSrcA=2, ALUSrcB=1. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD(3): ResultSrc=0, AdrSrc=1. Next: MEMWB.
  - MEMWB(4): ResultSrc=1, RegWrite=1. Next: FETCH.
  - MEMWRITE(5): ResultSrc=0, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR(6): ALUSrcA=2, ALUSrcB=0, ALUControl from funct decode. Next: ALUWB.
  - EXECI(7): ALUSrcA=2, ALUSrcB=1, ALUControl from funct decode. Next: ALUWB.
  - ALUWB(8): ResultSrc=0, RegWrite=1. Next: FETCH.
  - BRANCH(9): ALUSrcA=2, ALUSrcB=0, ALUControl=SUB, ResultSrc=0, PCWrite=taken. Next: FETCH.
  - JAL(10): ALUSrcA=1, ALUSrcB=2, ResultSrc=0, PCWrite=1. Next: ALUWB (writes OldPC+4).
  - JALR(11): ALUSrcA=2, ALUSrcB=1 (rs1+imm into ALUOut). Next: JALRPC.
  - JALRPC(12): ALUSrcA=1, ALUSrcB=2, ResultSrc=0, PCWrite=1. Next: ALUWB.
  - LUI(13): ResultSrc=3, RegWrite=1. Next: FETCH.
  - Codes 14–15: illegal; next state FETCH, outputs at defaults.
- Branch taken, by funct3:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: bge
  - others: 0
  - Flags are sampled combinationally in BRANCH.
- Funct decode, by funct3:
  - 000: SUB if op=0110011 and funct7b5=1, else ADD (ADDI always ADD)
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 110: OR
  - 111: AND
  - 001/101 (shifts, unsupported): ADD
- ImmSrc from op in every state: 0100011→S, 1100011→B, 1101111→J, 0110111→U, else I.
- Cycle counts: load 5, store 4, R/I-ALU 4, branch 3, JAL 4, JALR 5, LUI 3, NOP 2.

Decomposition:
- Shared package holds:
  - state enum, FETCH..LUI
  - ALU op constants, ADD..SLTU
  - opcode constants: LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI
  - ImmSrc and mux-select constants
- One sub-module, alu_decoder (combinational): inputs op, funct3, funct7b5, aluop_class (ADD/SUB/FUNCT); output ALUControl. Shared with any other controller in the codebase.

Test Plan:
- rst_n=0 asserted mid-EXECR, between clock edges → state=FETCH immediately, IRWrite=1, PCWrite=1, RegWrite=0, MemWrite=0.
- op=0110011, funct3=000, funct7b5=1 → states FETCH,DECODE,EXECR,ALUWB; ALUControl=1 in EXECR; RegWrite=1 only in ALUWB; back in FETCH on cycle 5.
- op=0000011 → 5-cycle sequence ending MEMWB with ResultSrc=1, RegWrite=1; AdrSrc=1 in MEMREAD. op=0100011 → MemWrite=1 for exactly one cycle.
- op=1100011: funct3=000 with zero=1 → PCWrite=1 in BRANCH. funct3=101 with bge=0 → PCWrite=0. funct3=100 with lt=1 → PCWrite=1; ALUControl=1 in all three cases.
- op=1100111 → JALR, JALRPC, ALUWB; PCWrite=1 only in FETCH and JALRPC; ALUSrcA=2 and ALUSrcB=1 in JALR.
- op=0001111 (unsupported) → DECODE returns to FETCH; no RegWrite or MemWrite. op=0110111 → LUI asserts ResultSrc=3, RegWrite=1, ImmSrc=4.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states, ALU op
// codes, opcodes, mux-select encodings and the immediate-format decode.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRPC   = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;
    localparam logic [1:0] RES_IMMEXT    = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_A     = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Immediate format depends only on the opcode, independent of FSM state.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the controller's ALU-op class and the
// instruction funct fields onto the ALUControl code.
module alu_decoder
    import multicycle_controller_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic [1:0]          aluop_class,
    output logic [ALUCTL_W-1:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (aluop_class)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type honours funct7b5; ADDI's bit 30 is immediate data.
                    3'b000:  ALUControl = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing each instruction and
// decoding datapath selects/enables from the current state.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALUCTL_W = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                lt,
    input  logic                bge,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl
);

    logic [STATE_W-1:0] state_reg;
    state_t             state_next;
    logic [1:0]         aluop_class;
    logic               branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = bge;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_t'(state_reg))
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_next = S_MEMWB;
            S_EXECR:   state_next = S_ALUWB;
            S_EXECI:   state_next = S_ALUWB;
            S_JAL:     state_next = S_ALUWB;
            S_JALR:    state_next = S_JALRPC;
            S_JALRPC:  state_next = S_ALUWB;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        aluop_class = ALUOP_ADD;
        case (state_t'(state_reg))
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA     = SRCA_A;
                aluop_class = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_IMM;
                aluop_class = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = SRCA_A;
                aluop_class = ALUOP_SUB;
                PCWrite     = branch_taken;
            end
            // JAL and JALRPC both load PC from ALUOut while computing OldPC+4 for the link.
            S_JAL, S_JALRPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ImmSrc = imm_sel(op);

    alu_decoder #(
        .ALUCTL_W(ALUCTL_W)
    ) u_alu_decoder (
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop_class(aluop_class),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle
// by cycle and compares the full output bundle against hand-built signatures.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       bge;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;

    int vectors;
    int miscompares;

    logic [18:0] obs;
    logic [18:0] exp_v [0:7];
    int          n_exp;

    multicycle_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .lt        (lt),
        .bge       (bge),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    function automatic logic [18:0] sig(input logic pcw, input logic adr, input logic mw,
                                         input logic irw, input logic rw, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [2:0] imm, input logic [2:0] alu);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
    endfunction

    function automatic logic [18:0] fetch_sig(input logic [2:0] imm);
        return sig(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, imm, 3'd0);
    endfunction

    function automatic logic [18:0] decode_sig(input logic [2:0] imm);
        return sig(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 3'd0);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; bge = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (obs !== fetch_sig(3'd0)) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", obs, fetch_sig(3'd0));
        end
        rst_n = 1'b1;
        $display("test_reset: 1 step checked");
    endtask

    task automatic test_rtype_sub();
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        zero = 1'b1; lt = 1'b1; bge = 1'b1;
        exp_v[0] = fetch_sig(3'd0);
        exp_v[1] = decode_sig(3'd0);
        exp_v[2] = sig(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1);
        exp_v[3] = sig(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
        exp_v[4] = fetch_sig(3'd0);
        n_exp = 5;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL rtype_sub step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_rtype_sub: %0d steps checked", n_exp);
    endtask

    task automatic test_itype();
        logic [2:0] f3_t  [0:2];
        logic       f7_t  [0:2];
        logic [2:0] alu_t [0:2];
        // ADDI with bit30 set still adds; XORI; SLTIU.
        f3_t[0] = 3'b000; f7_t[0] = 1'b1; alu_t[0] = 3'd0;
        f3_t[1] = 3'b100; f7_t[1] = 1'b0; alu_t[1] = 3'd4;
        f3_t[2] = 3'b011; f7_t[2] = 1'b0; alu_t[2] = 3'd6;
        for (int t = 0; t < 3; t++) begin
            op = 7'b0010011; funct3 = f3_t[t]; funct7b5 = f7_t[t];
            exp_v[0] = fetch_sig(3'd0);
            exp_v[1] = decode_sig(3'd0);
            exp_v[2] = sig(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, alu_t[t]);
            exp_v[3] = sig(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
            exp_v[4] = fetch_sig(3'd0);
            n_exp = 5;
            #1;
            for (int k = 0; k < n_exp; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                vectors++;
                if (obs !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL itype%0d step %0d: got %b expected %b", t, k, obs, exp_v[k]);
                end
            end
            $display("test_itype funct3=%b: %0d steps checked", f3_t[t], n_exp);
        end
    endtask

    task automatic test_load();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        exp_v[0] = fetch_sig(3'd0);
        exp_v[1] = decode_sig(3'd0);
        exp_v[2] = sig(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0);
        exp_v[3] = sig(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
        exp_v[4] = sig(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0);
        exp_v[5] = fetch_sig(3'd0);
        n_exp = 6;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL load step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_load: %0d steps checked", n_exp);
    endtask

    task automatic test_store();
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        exp_v[0] = fetch_sig(3'd1);
        exp_v[1] = decode_sig(3'd1);
        exp_v[2] = sig(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0);
        exp_v[3] = sig(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0);
        exp_v[4] = fetch_sig(3'd1);
        n_exp = 5;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL store step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_store: %0d steps checked", n_exp);
    endtask

    task automatic test_branch();
        logic [2:0] f3_t  [0:4];
        logic [2:0] flg_t [0:4];
        logic       tk_t  [0:4];
        // flags packed as {zero, lt, bge}
        f3_t[0] = 3'b000; flg_t[0] = 3'b100; tk_t[0] = 1'b1;
        f3_t[1] = 3'b101; flg_t[1] = 3'b110; tk_t[1] = 1'b0;
        f3_t[2] = 3'b100; flg_t[2] = 3'b010; tk_t[2] = 1'b1;
        f3_t[3] = 3'b001; flg_t[3] = 3'b100; tk_t[3] = 1'b0;
        f3_t[4] = 3'b110; flg_t[4] = 3'b111; tk_t[4] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            op = 7'b1100011; funct3 = f3_t[t]; funct7b5 = 1'b0;
            {zero, lt, bge} = flg_t[t];
            exp_v[0] = fetch_sig(3'd2);
            exp_v[1] = decode_sig(3'd2);
            exp_v[2] = sig(tk_t[t], 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd2, 3'd1);
            exp_v[3] = fetch_sig(3'd2);
            n_exp = 4;
            #1;
            for (int k = 0; k < n_exp; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                vectors++;
                if (obs !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL branch%0d step %0d: got %b expected %b", t, k, obs, exp_v[k]);
                end
            end
            $display("test_branch funct3=%b flags=%b: %0d steps checked", f3_t[t], flg_t[t], n_exp);
        end
        {zero, lt, bge} = 3'b000;
    endtask

    task automatic test_jal();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        exp_v[0] = fetch_sig(3'd3);
        exp_v[1] = decode_sig(3'd3);
        exp_v[2] = sig(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd3, 3'd0);
        exp_v[3] = sig(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd3, 3'd0);
        exp_v[4] = fetch_sig(3'd3);
        n_exp = 5;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL jal step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_jal: %0d steps checked", n_exp);
    endtask

    task automatic test_jalr();
        op = 7'b1100111; funct3 = 3'b000; funct7b5 = 1'b0;
        exp_v[0] = fetch_sig(3'd0);
        exp_v[1] = decode_sig(3'd0);
        exp_v[2] = sig(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0);
        exp_v[3] = sig(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0);
        exp_v[4] = sig(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
        exp_v[5] = fetch_sig(3'd0);
        n_exp = 6;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL jalr step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_jalr: %0d steps checked", n_exp);
    endtask

    task automatic test_nop_lui();
        op = 7'b0001111; funct3 = 3'b000; funct7b5 = 1'b0;
        exp_v[0] = fetch_sig(3'd0);
        exp_v[1] = decode_sig(3'd0);
        exp_v[2] = fetch_sig(3'd0);
        n_exp = 3;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL nop step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_nop: %0d steps checked", n_exp);
        op = 7'b0110111;
        exp_v[0] = fetch_sig(3'd4);
        exp_v[1] = decode_sig(3'd4);
        exp_v[2] = sig(0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, 3'd4, 3'd0);
        exp_v[3] = fetch_sig(3'd4);
        n_exp = 4;
        #1;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            vectors++;
            if (obs !== exp_v[k]) begin
                miscompares++;
                $display("FAIL lui step %0d: got %b expected %b", k, obs, exp_v[k]);
            end
        end
        $display("test_lui: %0d steps checked", n_exp);
    endtask

    task automatic test_reset_mid_execr();
        logic [18:0] execr_and;
        op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
        execr_and = sig(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd2);
        @(negedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (obs !== execr_and) begin
            miscompares++;
            $display("FAIL mid_reset_execr: got %b expected %b", obs, execr_and);
        end
        // Pull reset between edges; FETCH outputs must appear without a clock.
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== fetch_sig(3'd0)) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %b expected %b", obs, fetch_sig(3'd0));
        end
        @(posedge clk); #1;
        vectors++;
        if (obs !== fetch_sig(3'd0)) begin
            miscompares++;
            $display("FAIL mid_reset_held: got %b expected %b", obs, fetch_sig(3'd0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (obs !== decode_sig(3'd0)) begin
            miscompares++;
            $display("FAIL mid_reset_exit: got %b expected %b", obs, decode_sig(3'd0));
        end
        @(negedge clk); #1;
        vectors++;
        if (obs !== execr_and) begin
            miscompares++;
            $display("FAIL mid_reset_rerun: got %b expected %b", obs, execr_and);
        end
        @(negedge clk);
        @(negedge clk);
        $display("test_reset_mid_execr: 5 steps checked");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_rtype_sub();
        test_itype();
        test_load();
        test_store();
        test_branch();
        test_jal();
        test_jalr();
        test_nop_lui();
        test_reset_mid_execr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
